// File: rtl/evm_if.sv
// EVM stimulus/display bus: officer and voter controls in, registered display and status out.
interface evm_if #(
  parameter int N_CAND = 4,
  parameter int WIDTH  = 8
);
  localparam int CIDX_W = $clog2(N_CAND);

  logic              switch_on_evm;
  logic              candidate_ready;
  logic [N_CAND-1:0] vote_candidate;
  logic              voting_session_done;
  logic [CIDX_W-1:0] display_results;
  logic              display_winner;
  logic [CIDX_W-1:0] candidate_name;
  logic [WIDTH-1:0]  results;
  logic              invalid_results;
  logic              voting_in_progress;
  logic              voting_done;
  logic              vote_accepted;
  logic              tie;

  modport master (
    output switch_on_evm, candidate_ready, vote_candidate, voting_session_done,
           display_results, display_winner,
    input  candidate_name, results, invalid_results, voting_in_progress,
           voting_done, vote_accepted, tie
  );

  modport slave (
    input  switch_on_evm, candidate_ready, vote_candidate, voting_session_done,
           display_results, display_winner,
    output candidate_name, results, invalid_results, voting_in_progress,
           voting_done, vote_accepted, tie
  );
endinterface

// File: rtl/evm_multi_core.sv
// EVM control core: admits one voter at a time, counts one vote per admission with
// release lockout and timeout, then scans the tallies for a winner and serves readout.
module evm_multi_core #(
  parameter int N_CAND      = 4,
  parameter int WIDTH       = 8,
  parameter int TIMEOUT_CYC = 16
) (
  input logic  clk,
  input logic  rst,
  evm_if.slave bus
);
  localparam int CIDX_W = $clog2(N_CAND);
  localparam int TW     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [N_CAND-1:0] VOTE_ONE  = {{(N_CAND-1){1'b0}}, 1'b1};
  localparam logic [CIDX_W-1:0] LAST_IDX  = CIDX_W'(N_CAND - 1);
  localparam logic [TW-1:0]     TIMER_END = TW'(TIMEOUT_CYC - 1);
  localparam logic [WIDTH-1:0]  CNT_MAX   = {WIDTH{1'b1}};

  typedef enum logic [2:0] {
    S_OFF   = 3'd0,
    S_IDLE  = 3'd1,
    S_VOTE  = 3'd2,
    S_LOCK  = 3'd3,
    S_TALLY = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  cnt_q [N_CAND];
  logic [WIDTH-1:0]  cnt_d [N_CAND];
  logic [TW-1:0]     timer_q, timer_d;
  logic [CIDX_W-1:0] scan_q, scan_d, win_q, win_d;
  logic [WIDTH-1:0]  max_q, max_d;
  logic              tie_q, tie_d;

  logic [CIDX_W-1:0] name_q, name_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic              inv_q, inv_d, vip_q, vip_d, done_q, done_d, acc_q, acc_d, tieo_q, tieo_d;

  logic              vote_ok_s;
  logic [CIDX_W-1:0] vote_idx_s;
  logic [WIDTH-1:0]  cur_s;

  function automatic logic is_onehot(input logic [N_CAND-1:0] v);
    return (v != {N_CAND{1'b0}}) && ((v & (v - VOTE_ONE)) == {N_CAND{1'b0}});
  endfunction

  function automatic logic [CIDX_W-1:0] onehot_idx(input logic [N_CAND-1:0] v);
    logic [CIDX_W-1:0] idx;
    idx = {CIDX_W{1'b0}};
    for (int i = 0; i < N_CAND; i++) begin
      if (v[i]) begin
        idx = CIDX_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  assign vote_ok_s  = is_onehot(bus.vote_candidate);
  assign vote_idx_s = onehot_idx(bus.vote_candidate);

  // Next-state, counter, tally and registered-output computation
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    timer_d = timer_q;
    scan_d  = scan_q;
    win_d   = win_q;
    max_d   = max_q;
    tie_d   = tie_q;
    name_d  = {CIDX_W{1'b0}};
    res_d   = {WIDTH{1'b0}};
    inv_d   = 1'b0;
    acc_d   = 1'b0;
    tieo_d  = 1'b0;
    cur_s   = cnt_q[scan_q];

    if (!bus.switch_on_evm) begin
      state_d = S_OFF;
    end else begin
      case (state_q)
        S_OFF: begin
          state_d = S_IDLE;
          for (int i = 0; i < N_CAND; i++) cnt_d[i] = {WIDTH{1'b0}};
        end
        S_IDLE: begin
          if (bus.voting_session_done) begin
            state_d = S_TALLY;
            scan_d  = {CIDX_W{1'b0}};
          end else if (bus.candidate_ready) begin
            state_d = S_VOTE;
            timer_d = {TW{1'b0}};
          end else begin
            state_d = S_IDLE;
          end
        end
        S_VOTE: begin
          if (vote_ok_s) begin
            if (cnt_q[vote_idx_s] != CNT_MAX) begin
              cnt_d[vote_idx_s] = cnt_q[vote_idx_s] + {{(WIDTH-1){1'b0}}, 1'b1};
            end else begin
              cnt_d[vote_idx_s] = CNT_MAX;
            end
            acc_d   = 1'b1;
            state_d = S_LOCK;
          end else if (timer_q == TIMER_END) begin
            state_d = S_IDLE;
          end else begin
            timer_d = timer_q + {{(TW-1){1'b0}}, 1'b1};
          end
        end
        S_LOCK: begin
          if (bus.vote_candidate == {N_CAND{1'b0}}) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_LOCK;
          end
        end
        S_TALLY: begin
          // Index 0 seeds the scan so an all-zero tally ends as winner 0 with a tie
          if (scan_q == {CIDX_W{1'b0}}) begin
            max_d = cur_s;
            win_d = {CIDX_W{1'b0}};
            tie_d = 1'b0;
          end else if (cur_s > max_q) begin
            max_d = cur_s;
            win_d = scan_q;
            tie_d = 1'b0;
          end else if (cur_s == max_q) begin
            tie_d = 1'b1;
          end else begin
            tie_d = tie_q;
          end
          if (scan_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            scan_d = scan_q + {{(CIDX_W-1){1'b0}}, 1'b1};
          end
        end
        S_DONE: begin
          if (bus.display_winner) begin
            name_d = win_q;
            res_d  = max_q;
            tieo_d = tie_q;
          end else if (int'(bus.display_results) < N_CAND) begin
            name_d = bus.display_results;
            res_d  = cnt_q[bus.display_results];
          end else begin
            name_d = bus.display_results;
            inv_d  = 1'b1;
          end
        end
        default: begin
          state_d = S_OFF;
        end
      endcase
    end

    vip_d  = (state_d == S_VOTE);
    done_d = (state_d == S_DONE);
  end

  // State, counters, tally bookkeeping and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_OFF;
      for (int i = 0; i < N_CAND; i++) cnt_q[i] <= {WIDTH{1'b0}};
      timer_q <= {TW{1'b0}};
      scan_q  <= {CIDX_W{1'b0}};
      win_q   <= {CIDX_W{1'b0}};
      max_q   <= {WIDTH{1'b0}};
      tie_q   <= 1'b0;
      name_q  <= {CIDX_W{1'b0}};
      res_q   <= {WIDTH{1'b0}};
      inv_q   <= 1'b0;
      vip_q   <= 1'b0;
      done_q  <= 1'b0;
      acc_q   <= 1'b0;
      tieo_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
      scan_q  <= scan_d;
      win_q   <= win_d;
      max_q   <= max_d;
      tie_q   <= tie_d;
      name_q  <= name_d;
      res_q   <= res_d;
      inv_q   <= inv_d;
      vip_q   <= vip_d;
      done_q  <= done_d;
      acc_q   <= acc_d;
      tieo_q  <= tieo_d;
    end
  end

  assign bus.candidate_name     = name_q;
  assign bus.results            = res_q;
  assign bus.invalid_results    = inv_q;
  assign bus.voting_in_progress = vip_q;
  assign bus.voting_done        = done_q;
  assign bus.vote_accepted      = acc_q;
  assign bus.tie                = tieo_q;
endmodule

// File: tb/tb_evm_multi_core.sv
// Directed bench for evm_multi_core: a 4-candidate/8-bit core and a 6-candidate/2-bit core.
module tb_evm_multi_core;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   acc_sum;

  always #5 clk = ~clk;

  evm_if #(.N_CAND(4), .WIDTH(8)) ia ();
  evm_if #(.N_CAND(6), .WIDTH(2)) ib ();

  evm_multi_core #(.N_CAND(4), .WIDTH(8), .TIMEOUT_CYC(16)) dut_a (.clk(clk), .rst(rst), .bus(ia));
  evm_multi_core #(.N_CAND(6), .WIDTH(2), .TIMEOUT_CYC(4))  dut_b (.clk(clk), .rst(rst), .bus(ib));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic vote_a(input logic [3:0] v);
    ia.candidate_ready = 1'b1;
    tick();
    ia.candidate_ready = 1'b0;
    ia.vote_candidate  = v;
    tick();
    ia.vote_candidate  = 4'b0000;
    tick();
  endtask

  task automatic vote_b(input logic [5:0] v);
    ib.candidate_ready = 1'b1;
    tick();
    ib.candidate_ready = 1'b0;
    ib.vote_candidate  = v;
    tick();
    ib.vote_candidate  = 6'b000000;
    tick();
  endtask

  task automatic close_a();
    ia.voting_session_done = 1'b1;
    tick();
    ia.voting_session_done = 1'b0;
    repeat (3) tick();
    chk("a_tally_not_done", {31'd0, ia.voting_done}, 32'd0);
    tick();
    chk("a_tally_done", {31'd0, ia.voting_done}, 32'd1);
  endtask

  task automatic read_a(input string tag, input logic win, input logic [1:0] idx,
                        input logic [1:0] exp_name, input logic [7:0] exp_res, input logic exp_tie);
    ia.display_winner  = win;
    ia.display_results = idx;
    tick();
    chk({tag, "_name"}, {30'd0, ia.candidate_name}, {30'd0, exp_name});
    chk({tag, "_res"},  {24'd0, ia.results}, {24'd0, exp_res});
    chk({tag, "_tie"},  {31'd0, ia.tie}, {31'd0, exp_tie});
  endtask

  task automatic read_b(input string tag, input logic win, input logic [2:0] idx,
                        input logic [2:0] exp_name, input logic [1:0] exp_res, input logic exp_inv);
    ib.display_winner  = win;
    ib.display_results = idx;
    tick();
    chk({tag, "_name"}, {29'd0, ib.candidate_name}, {29'd0, exp_name});
    chk({tag, "_res"},  {30'd0, ib.results}, {30'd0, exp_res});
    chk({tag, "_inv"},  {31'd0, ib.invalid_results}, {31'd0, exp_inv});
  endtask

  function automatic logic [31:0] pack_a();
    return {18'd0, ia.candidate_name, ia.results, ia.invalid_results, ia.voting_in_progress,
            ia.voting_done, ia.vote_accepted, ia.tie};
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    ia.switch_on_evm = 1'b0; ia.candidate_ready = 1'b0; ia.vote_candidate = 4'b0000;
    ia.voting_session_done = 1'b0; ia.display_results = 2'd0; ia.display_winner = 1'b0;
    ib.switch_on_evm = 1'b0; ib.candidate_ready = 1'b0; ib.vote_candidate = 6'b000000;
    ib.voting_session_done = 1'b0; ib.display_results = 3'd0; ib.display_winner = 1'b0;

    // reset state
    tick(); tick();
    chk("reset_outputs", pack_a(), 32'd0);
    rst = 1'b1;
    ia.switch_on_evm = 1'b1;
    tick();
    chk("idle_no_vip", {31'd0, ia.voting_in_progress}, 32'd0);

    // three votes for candidate 2
    ia.candidate_ready = 1'b1;
    tick();
    chk("vote_vip", {31'd0, ia.voting_in_progress}, 32'd1);
    ia.candidate_ready = 1'b0;
    ia.vote_candidate  = 4'b0100;
    tick();
    ia.vote_candidate  = 4'b0000;
    tick();
    vote_a(4'b0100);
    vote_a(4'b0100);

    // held button counts once
    ia.candidate_ready = 1'b1;
    tick();
    ia.candidate_ready = 1'b0;
    ia.vote_candidate  = 4'b0001;
    acc_sum = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      acc_sum += int'(ia.vote_accepted);
      if (i == 0) chk("hold_lock_vip", {31'd0, ia.voting_in_progress}, 32'd0);
    end
    chk("hold_acc_pulses", acc_sum, 32'd1);
    ia.vote_candidate = 4'b0000;
    tick();

    // multi-hot ignored, then valid one-hot
    ia.candidate_ready = 1'b1;
    tick();
    ia.candidate_ready = 1'b0;
    ia.vote_candidate  = 4'b0110;
    tick(); tick();
    chk("multihot_vip", {31'd0, ia.voting_in_progress}, 32'd1);
    chk("multihot_acc", {31'd0, ia.vote_accepted}, 32'd0);
    ia.vote_candidate = 4'b0100;
    tick();
    chk("onehot_acc", {31'd0, ia.vote_accepted}, 32'd1);
    ia.vote_candidate = 4'b0000;
    tick();

    // timeout after 16 cycles with no press
    ia.candidate_ready = 1'b1;
    tick();
    ia.candidate_ready = 1'b0;
    repeat (15) tick();
    chk("timeout_vip_last", {31'd0, ia.voting_in_progress}, 32'd1);
    tick();
    chk("timeout_vip_off", {31'd0, ia.voting_in_progress}, 32'd0);

    // tally session 1: c0=1 c2=4
    close_a();
    read_a("s1_cand2", 1'b0, 2'd2, 2'd2, 8'd4, 1'b0);
    read_a("s1_cand0", 1'b0, 2'd0, 2'd0, 8'd1, 1'b0);
    read_a("s1_cand3", 1'b0, 2'd3, 2'd3, 8'd0, 1'b0);
    read_a("s1_win",   1'b1, 2'd0, 2'd2, 8'd4, 1'b0);
    chk("s1_inv", {31'd0, ia.invalid_results}, 32'd0);

    // session 2: tie between 0 and 3
    ia.display_winner = 1'b0;
    ia.switch_on_evm = 1'b0;
    tick();
    chk("off_done_low", {31'd0, ia.voting_done}, 32'd0);
    ia.switch_on_evm = 1'b1;
    tick();
    vote_a(4'b0001); vote_a(4'b1000); vote_a(4'b0001); vote_a(4'b1000);
    close_a();
    read_a("s2_win",   1'b1, 2'd0, 2'd0, 8'd2, 1'b1);
    read_a("s2_cand1", 1'b0, 2'd1, 2'd1, 8'd0, 1'b0);
    ia.candidate_ready = 1'b1;
    tick();
    ia.candidate_ready = 1'b0;
    chk("s2_done_holds", {31'd0, ia.voting_done}, 32'd1);

    // reset during VOTE
    ia.switch_on_evm = 1'b0;
    tick();
    ia.switch_on_evm = 1'b1;
    tick();
    vote_a(4'b0100);
    ia.candidate_ready = 1'b1;
    tick();
    ia.candidate_ready = 1'b0;
    chk("pre_rst_vip", {31'd0, ia.voting_in_progress}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_outputs", pack_a(), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    close_a();
    read_a("s3_cand2", 1'b0, 2'd2, 2'd2, 8'd0, 1'b0);
    read_a("s3_win",   1'b1, 2'd0, 2'd0, 8'd0, 1'b1);

    // second core: 6 candidates, 2-bit saturating counters, 4-cycle timeout
    ib.switch_on_evm = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) vote_b(6'b000010);
    ib.candidate_ready = 1'b1;
    tick();
    ib.candidate_ready = 1'b0;
    repeat (3) tick();
    chk("b_timeout_vip_last", {31'd0, ib.voting_in_progress}, 32'd1);
    tick();
    chk("b_timeout_vip_off", {31'd0, ib.voting_in_progress}, 32'd0);
    ib.voting_session_done = 1'b1;
    tick();
    ib.voting_session_done = 1'b0;
    repeat (5) tick();
    chk("b_tally_not_done", {31'd0, ib.voting_done}, 32'd0);
    tick();
    chk("b_tally_done", {31'd0, ib.voting_done}, 32'd1);
    read_b("b_cand1_sat", 1'b0, 3'd1, 3'd1, 2'd3, 1'b0);
    read_b("b_cand0",     1'b0, 3'd0, 3'd0, 2'd0, 1'b0);
    read_b("b_cand5",     1'b0, 3'd5, 3'd5, 2'd0, 1'b0);
    read_b("b_idx6",      1'b0, 3'd6, 3'd6, 2'd0, 1'b1);
    read_b("b_idx7",      1'b0, 3'd7, 3'd7, 2'd0, 1'b1);
    read_b("b_win",       1'b1, 3'd7, 3'd1, 2'd3, 1'b0);
    chk("b_win_tie", {31'd0, ib.tie}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
